bot_sprite_engine: RTL and testbench

Parametrised sprite renderer for one Rojobot on the VGA pixel pipeline. It maps the bot's world location to a screen window and generates the sprite ROM address from the pixel position. It selects the heading image or the explosion image and drives a colour plus an opaque flag to the colouriser. A hit/explode/respawn sequencer with a programmable explosion time is built in. It replaces fixed 16x16 renderers that used free-running address counters.

---
 rtl/bot_sprite_pkg.sv | 39 +++
 rtl/bot_sprite_engine_if.sv | 46 ++++
 rtl/bot_burst_seq.sv | 84 ++++++++
 rtl/bot_sprite_engine.sv | 150 +++++++++++++++
 tb/tb_bot_sprite_engine.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bot_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bot_sprite_pkg
// Purpose  : Shared types and constants for the Rojobot sprite engine:
//            burst sequencer states, bot_info heading codes, sprite_sel
//            image encodings and the default see-through colour.
// Revision : 1.0 - initial release
// ============================================================================
package bot_sprite_pkg;

  // Hit / explode / respawn sequencer states
  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_BURST   = 2'd1,
    ST_RESPAWN = 2'd2
  } seq_state_t;

  // Heading codes carried in bot_info[2:0]; odd codes are diagonals
  localparam logic [2:0] C_HEAD_N = 3'd0;
  localparam logic [2:0] C_HEAD_E = 3'd2;
  localparam logic [2:0] C_HEAD_S = 3'd4;
  localparam logic [2:0] C_HEAD_W = 3'd6;

  // Image select encodings driven on sprite_sel
  localparam logic [1:0] C_SEL_N = 2'd0;
  localparam logic [1:0] C_SEL_E = 2'd1;
  localparam logic [1:0] C_SEL_S = 2'd2;
  localparam logic [1:0] C_SEL_W = 2'd3;

  // Colour treated as see-through unless overridden
  localparam logic [11:0] C_TRANSPARENT_DEFAULT = 12'hFFF;

  // Cardinal heading code -> image select (code >> 1)
  function automatic logic [1:0] head_to_sel(input logic [2:0] code);
    return code[2:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bot_sprite_engine_if.sv
`default_nettype none
// ============================================================================
// Interface: bot_sprite_engine_if
// Purpose  : Pixel-pipeline bundle between the scan/ROM/colouriser side
//            (master) and the sprite engine (slave).
// Signals  : pixel_column/pixel_row  scan position
//            loc_x/loc_y/bot_info     bot world position and heading
//            hit                      bot struck
//            sprite_addr/sprite_sel   ROM address and image select
//            sprite_data/boom_data    heading / explosion ROM read data
//            icon/icon_flag           pixel colour and draw flag
//            burst/bot_reset          explosion active / respawn request
// Revision : 1.0 - initial release
// ============================================================================
interface bot_sprite_engine_if #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 8
);
  logic [11:0]       pixel_column;
  logic [11:0]       pixel_row;
  logic [7:0]        loc_x;
  logic [7:0]        loc_y;
  logic [7:0]        bot_info;
  logic              hit;
  logic [ADDR_W-1:0] sprite_addr;
  logic [1:0]        sprite_sel;
  logic [PIX_W-1:0]  sprite_data;
  logic [PIX_W-1:0]  boom_data;
  logic [PIX_W-1:0]  icon;
  logic              icon_flag;
  logic              burst;
  logic              bot_reset;

  modport master (
    output pixel_column, pixel_row, loc_x, loc_y, bot_info, hit,
           sprite_data, boom_data,
    input  sprite_addr, sprite_sel, icon, icon_flag, burst, bot_reset
  );

  modport slave (
    input  pixel_column, pixel_row, loc_x, loc_y, bot_info, hit,
           sprite_data, boom_data,
    output sprite_addr, sprite_sel, icon, icon_flag, burst, bot_reset
  );
endinterface
`default_nettype wire

// File: rtl/bot_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : bot_burst_seq
// Purpose  : Hit / explode / respawn sequencer. A hit while alive starts an
//            explosion of BURST_CYCLES clocks (restarted by further hits),
//            followed by a RESPAWN_CYCLES-clock bot_reset pulse during which
//            hits are ignored.
// Ports    : clk       pixel clock
//            reset     asynchronous, active-high
//            hit       bot struck (pulse or level)
//            burst     explosion in progress
//            bot_reset respawn request
// Revision : 1.0 - initial release
// ============================================================================
module bot_burst_seq
  import bot_sprite_pkg::*;
#(
  parameter int unsigned BURST_CYCLES   = 32'h3000000,
  parameter int unsigned RESPAWN_CYCLES = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  output logic burst,
  output logic bot_reset
);

  localparam logic [31:0] C_BURST_LAST   = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] C_RESPAWN_LAST = 32'(RESPAWN_CYCLES - 1);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ALIVE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are pure state decodes so reset clears them without a clock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 32'd1;
    burst       = 1'b0;
    bot_reset   = 1'b0;
    case (r_state)
      ST_ALIVE: begin
        w_cnt_nxt = '0;
        if (hit) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        burst = 1'b1;
        // A fresh hit takes priority over expiry so the explosion restarts.
        if (hit) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_BURST_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RESPAWN;
        end
      end
      ST_RESPAWN: begin
        bot_reset = 1'b1;
        if (r_cnt == C_RESPAWN_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ALIVE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_ALIVE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bot_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : bot_sprite_engine
// Purpose  : Sprite renderer for one Rojobot. Maps the bot world location to
//            a screen window, generates the row-major sprite ROM address,
//            selects heading or explosion image and drives icon/icon_flag
//            with a fixed 3-clock latency from pixel to icon.
// Ports    : clk    pixel clock
//            reset  asynchronous, active-high
//            bus    bot_sprite_engine_if.slave (scan position, bot state,
//                   ROM address/data, icon outputs, burst/bot_reset)
// Config   : BOT_SPRITE_MIRROR_EN - only N and E images are stored; S and W
//            are drawn by flipping the row / column index of N / E.
// Revision : 1.0 - initial release
// ============================================================================
module bot_sprite_engine
  import bot_sprite_pkg::*;
#(
  parameter int              SPRITE_W       = 16,
  parameter int              SPRITE_H       = 16,
  parameter int              SCALE_X        = 8,
  parameter int              SCALE_Y        = 6,
  parameter int              PIX_W          = 12,
  parameter logic [PIX_W-1:0] TRANSPARENT   = PIX_W'(C_TRANSPARENT_DEFAULT),
  parameter int unsigned     BURST_CYCLES   = 32'h3000000,
  parameter int unsigned     RESPAWN_CYCLES = 17
) (
  input  logic                clk,
  input  logic                reset,
  bot_sprite_engine_if.slave  bus
);

  localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H);

  // Window geometry, all at 13 bits so a window near 4095 never wraps.
  logic [12:0]       w_col;
  logic [12:0]       w_row;
  logic [12:0]       w_col_org;
  logic [12:0]       w_row_org;
  logic [12:0]       w_dc;
  logic [12:0]       w_dr;
  logic [12:0]       w_c_idx;
  logic [12:0]       w_r_idx;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_addr;

  logic [1:0]        r_head;
  logic [1:0]        w_head;
  logic [1:0]        w_sel;
  logic              w_flip_r;
  logic              w_flip_c;

  logic              w_burst;
  logic              w_bot_reset;

  logic [ADDR_W-1:0] r_sprite_addr;
  logic [1:0]        r_sprite_sel;
  logic              r_win1;
  logic              r_win2;
  logic              r_burst_d1;
  logic              r_burst_d2;
  logic [PIX_W-1:0]  r_icon;
  logic              r_icon_flag;
  logic [PIX_W-1:0]  w_rom;
  logic [PIX_W-1:0]  w_icon_nxt;
  logic              w_flag_nxt;
  logic              w_unused_info;

  assign w_unused_info = &{1'b0, bus.bot_info[7:3]};

  assign w_col     = {1'b0, bus.pixel_column};
  assign w_row     = {1'b0, bus.pixel_row};
  assign w_col_org = {5'd0, bus.loc_x} * 13'(SCALE_X);
  assign w_row_org = {5'd0, bus.loc_y} * 13'(SCALE_Y);
  assign w_in_win  = (w_col >= w_col_org) && (w_col < w_col_org + 13'(SPRITE_W)) &&
                     (w_row >= w_row_org) && (w_row < w_row_org + 13'(SPRITE_H));
  assign w_dc      = w_col - w_col_org;
  assign w_dr      = w_row - w_row_org;

  // Diagonal (odd) codes hold the last cardinal; the live value feeds the
  // address stage directly so a new heading lands on the next registered
  // sprite_sel together with its matching address.
  assign w_head = bus.bot_info[0] ? r_head : head_to_sel(bus.bot_info[2:0]);

`ifdef BOT_SPRITE_MIRROR_EN
  assign w_flip_r = (w_head == C_SEL_S);
  assign w_flip_c = (w_head == C_SEL_W);
  assign w_sel    = {1'b0, w_head[0]};
`else
  assign w_flip_r = 1'b0;
  assign w_flip_c = 1'b0;
  assign w_sel    = w_head;
`endif

  assign w_r_idx = w_flip_r ? (13'(SPRITE_H - 1) - w_dr) : w_dr;
  assign w_c_idx = w_flip_c ? (13'(SPRITE_W - 1) - w_dc) : w_dc;
  assign w_addr  = ADDR_W'(w_r_idx * 13'(SPRITE_W) + w_c_idx);

  bot_burst_seq #(
    .BURST_CYCLES   (BURST_CYCLES),
    .RESPAWN_CYCLES (RESPAWN_CYCLES)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .hit       (bus.hit),
    .burst     (w_burst),
    .bot_reset (w_bot_reset)
  );

  // ROM data belongs to the pixel two stages back, so the image choice and
  // the flag both use the window/burst state delayed by the same two stages.
  assign w_rom      = r_burst_d2 ? bus.boom_data : bus.sprite_data;
  assign w_icon_nxt = r_win2 ? w_rom : '0;
  assign w_flag_nxt = r_win2 && (w_rom != TRANSPARENT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head        <= C_SEL_N;
      r_sprite_addr <= '0;
      r_sprite_sel  <= C_SEL_N;
      r_win1        <= 1'b0;
      r_win2        <= 1'b0;
      r_burst_d1    <= 1'b0;
      r_burst_d2    <= 1'b0;
      r_icon        <= '0;
      r_icon_flag   <= 1'b0;
    end else begin
      r_head       <= w_head;
      r_sprite_sel <= w_sel;
      if (w_in_win) begin
        r_sprite_addr <= w_addr;
      end
      r_win1      <= w_in_win;
      r_win2      <= r_win1;
      r_burst_d1  <= w_burst;
      r_burst_d2  <= r_burst_d1;
      r_icon      <= w_icon_nxt;
      r_icon_flag <= w_flag_nxt;
    end
  end

  assign bus.sprite_addr = r_sprite_addr;
  assign bus.sprite_sel  = r_sprite_sel;
  assign bus.icon        = r_icon;
  assign bus.icon_flag   = r_icon_flag;
  assign bus.burst       = w_burst;
  assign bus.bot_reset   = w_bot_reset;

endmodule
`default_nettype wire

// File: tb/tb_bot_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bot_sprite_engine
// Purpose  : Directed self-checking bench for bot_sprite_engine (default
//            four-image build) with BURST_CYCLES=8, RESPAWN_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bot_sprite_engine;

  localparam int SW = 16;
  localparam int SH = 16;
  localparam int PW = 12;
  localparam int AW = 8;
  localparam int BC = 8;
  localparam int RC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int trans_addr = -1;
  logic [AW-1:0] exp_addr = '0;

  bot_sprite_engine_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  bot_sprite_engine #(
    .SPRITE_W       (SW),
    .SPRITE_H       (SH),
    .SCALE_X        (8),
    .SCALE_Y        (6),
    .PIX_W          (PW),
    .TRANSPARENT    (12'hFFF),
    .BURST_CYCLES   (BC),
    .RESPAWN_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models: heading image word = {sel, 2'b00, addr},
  // explosion word = {4'hB, addr}; optional forced see-through address.
  always @(posedge clk) begin
    bus.sprite_data <= (int'(bus.sprite_addr) == trans_addr) ? 12'hFFF
                       : {bus.sprite_sel, 2'b00, bus.sprite_addr};
    bus.boom_data   <= {4'hB, bus.sprite_addr};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.pixel_column = 12'd4000;
    bus.pixel_row    = 12'd4000;
    bus.loc_x        = 8'd10;
    bus.loc_y        = 8'd10;
    bus.bot_info     = 8'd0;
    bus.hit          = 1'b0;
    reset            = 1'b1;
    #12;
    checks++; if (bus.icon !== 12'h000) begin errors++; $display("FAIL rst_icon got %0h want 0", bus.icon); end
    checks++; if (bus.icon_flag !== 1'b0) begin errors++; $display("FAIL rst_flag got %0b want 0", bus.icon_flag); end
    checks++; if (bus.burst !== 1'b0) begin errors++; $display("FAIL rst_burst got %0b want 0", bus.burst); end
    checks++; if (bus.bot_reset !== 1'b0) begin errors++; $display("FAIL rst_botreset got %0b want 0", bus.bot_reset); end
    checks++; if (bus.sprite_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", bus.sprite_addr); end
    checks++; if (bus.sprite_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", bus.sprite_sel); end
    step();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      checks++; if (bus.burst !== 1'b0 || bus.icon_flag !== 1'b0) begin
        errors++; $display("FAIL post_rst_idle got burst=%0b flag=%0b want 0/0", bus.burst, bus.icon_flag);
      end
    end
  endtask

  task automatic test_heading();
    logic [7:0] info_v [7] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd1, 8'd2};
    logic [1:0] sel_v  [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 7; i++) begin
      bus.bot_info = info_v[i];
      step();
      checks++; if (bus.sprite_sel !== sel_v[i]) begin
        errors++; $display("FAIL heading_%0d got sel %0d want %0d", info_v[i], bus.sprite_sel, sel_v[i]);
      end
    end
  endtask

  task automatic test_scan(input string nm, input int lx, input int ly, input int org_c,
                           input int org_r, input int row, input int lead, input int first,
                           input int n, input int tr);
    int pc[$];
    int c;
    int a;
    bit win;
    logic [11:0] e_icon;
    logic e_flag;
    trans_addr = tr;
    pc.push_back(lead);
    for (int i = 0; i < n; i++) pc.push_back(first + i);
    for (int i = 0; i < 3; i++) pc.push_back(4000);
    bus.loc_x = 8'(lx);
    bus.loc_y = 8'(ly);
    for (int s = 0; s <= pc.size(); s++) begin
      if (s > 0) step();
      if (s >= 1) begin
        c = pc[s-1];
        win = (c >= org_c) && (c < org_c + SW) && (row >= org_r) && (row < org_r + SH);
        if (win) exp_addr = AW'((row - org_r) * SW + (c - org_c));
        checks++; if (bus.sprite_addr !== exp_addr || bus.sprite_sel !== 2'd1) begin
          errors++; $display("FAIL %s_addr col %0d got %0d/sel %0d want %0d/sel 1", nm, c, bus.sprite_addr, bus.sprite_sel, exp_addr);
        end
      end
      if (s >= 3) begin
        c = pc[s-3];
        win = (c >= org_c) && (c < org_c + SW) && (row >= org_r) && (row < org_r + SH);
        a = (row - org_r) * SW + (c - org_c);
        if (win) begin
          e_icon = (a == tr) ? 12'hFFF : {2'b01, 2'b00, 8'(a)};
          e_flag = (a != tr);
        end else begin
          e_icon = 12'h000;
          e_flag = 1'b0;
        end
        checks++; if (bus.icon !== e_icon || bus.icon_flag !== e_flag) begin
          errors++; $display("FAIL %s_icon col %0d got %0h/%0b want %0h/%0b", nm, c, bus.icon, bus.icon_flag, e_icon, e_flag);
        end
      end
      if (s < pc.size()) begin
        bus.pixel_column = 12'(pc[s]);
        bus.pixel_row    = 12'(row);
      end
    end
    trans_addr = -1;
  endtask

  task automatic test_burst_single();
    bus.loc_x = 8'd10;
    bus.loc_y = 8'd10;
    bus.pixel_column = 12'd4000;
    step();
    bus.hit = 1'b1;
    for (int s = 1; s <= 14; s++) begin
      step();
      if (s == 1) bus.hit = 1'b0;
      checks++; if (bus.burst !== (s <= BC) || bus.bot_reset !== (s > BC && s <= BC + RC)) begin
        errors++; $display("FAIL burst1 clk %0d got burst=%0b rst=%0b", s, bus.burst, bus.bot_reset);
      end
      if (s == 3) begin
        exp_addr = 8'd3;
        checks++; if (bus.sprite_addr !== 8'd3) begin errors++; $display("FAIL burst_addr got %0d want 3", bus.sprite_addr); end
      end
      if (s == 5) begin
        checks++; if (bus.icon !== 12'hB03 || bus.icon_flag !== 1'b1) begin
          errors++; $display("FAIL boom_icon got %0h/%0b want b03/1", bus.icon, bus.icon_flag);
        end
      end
      if (s == 2) begin bus.pixel_column = 12'd83; bus.pixel_row = 12'd60; end
      if (s == 3) bus.pixel_column = 12'd4000;
    end
  endtask

  task automatic test_back_to_back_hit();
    step();
    bus.hit = 1'b1;
    for (int s = 1; s <= 17; s++) begin
      step();
      checks++; if (bus.burst !== (s <= 13) || bus.bot_reset !== (s >= 14 && s <= 16)) begin
        errors++; $display("FAIL rehit clk %0d got burst=%0b rst=%0b", s, bus.burst, bus.bot_reset);
      end
      bus.hit = (s == 5);
    end
  endtask

  task automatic test_respawn_ignore();
    step();
    bus.hit = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      step();
      checks++; if (bus.burst !== (s <= BC) || bus.bot_reset !== (s > BC && s <= BC + RC)) begin
        errors++; $display("FAIL respawn_ign clk %0d got burst=%0b rst=%0b", s, bus.burst, bus.bot_reset);
      end
      bus.hit = (s == 9) || (s == 10);
    end
  endtask

  task automatic test_reset_mid_burst();
    step();
    bus.hit = 1'b1;
    bus.pixel_column = 12'd81;
    bus.pixel_row = 12'd60;
    step();
    bus.hit = 1'b0;
    bus.pixel_column = 12'd4000;
    step();
    step();
    checks++; if (bus.burst !== 1'b1 || bus.icon !== 12'h401 || bus.sprite_addr !== 8'd1) begin
      errors++; $display("FAIL pre_reset got burst=%0b icon=%0h addr=%0d want 1/401/1", bus.burst, bus.icon, bus.sprite_addr);
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.burst !== 1'b0 || bus.bot_reset !== 1'b0) begin
      errors++; $display("FAIL async_rst got burst=%0b rst=%0b want 0/0", bus.burst, bus.bot_reset);
    end
    checks++; if (bus.icon !== 12'h000 || bus.icon_flag !== 1'b0 || bus.sprite_addr !== 8'd0 || bus.sprite_sel !== 2'd0) begin
      errors++; $display("FAIL async_rst_out got icon=%0h flag=%0b addr=%0d sel=%0d want 0", bus.icon, bus.icon_flag, bus.sprite_addr, bus.sprite_sel);
    end
    step();
    reset = 1'b0;
    exp_addr = '0;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (bus.burst !== 1'b0 || bus.bot_reset !== 1'b0) begin
        errors++; $display("FAIL after_rst got burst=%0b rst=%0b want 0/0", bus.burst, bus.bot_reset);
      end
    end
  endtask

  initial begin
    test_reset();
    test_heading();
    test_scan("win", 10, 10, 80, 60, 60, 77, 78, 21, -1);
    test_scan("transp", 10, 10, 80, 60, 60, 77, 78, 21, 5);
    test_scan("corner", 255, 255, 2040, 1530, 1530, 0, 2038, 6, -1);
    test_burst_single();
    test_back_to_back_hit();
    test_respawn_ignore();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
